// File: rtl/wb_regfile_pkg.sv
// Shared integer-pipeline types and constants for the write-back / register-file slice.
package rv_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_addr_t REG_ZERO = '0;

    // Read-port priority: reset, then x0, then the same-cycle write-through, then the array.
    function automatic xword_t bypass_read(
        input logic      reset,
        input reg_addr_t addr,
        input logic      wb_we,
        input reg_addr_t wb_rd,
        input xword_t    wb_data,
        input xword_t    raw
    );
        xword_t value;
        value = raw;
        if (reset) begin
            value = '0;
        end else if (addr == REG_ZERO) begin
            value = '0;
        end else if (wb_we && (addr == wb_rd)) begin
            value = wb_data;
        end
        return value;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB, ID-stage read and forwarding signals bundled for the write-back / register-file block.
interface wb_regfile_if;
    import rv_pkg::*;

    // MEM/WB pipeline register outputs
    logic      memtoreg;
    logic      regwrite;
    reg_addr_t rd;
    xword_t    readdata;
    xword_t    result_alu;

    // ID-stage read ports
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    xword_t    rs1_data;
    xword_t    rs2_data;

    // Forwarding-unit export and retirement counter
    xword_t    wb_data;
    reg_addr_t wb_rd;
    logic      wb_we;
    xword_t    wb_count;

    modport master (
        output memtoreg, regwrite, rd, readdata, result_alu, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, wb_data, wb_rd, wb_we, wb_count
    );

    modport slave (
        input  memtoreg, regwrite, rd, readdata, result_alu, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, wb_data, wb_rd, wb_we, wb_count
    );

endinterface

// File: rtl/wb_regfile_regfile_core.sv
// Flop-based 32 x XLEN integer register array: one write port, two raw read ports.
module regfile_core
    import rv_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_we,
    input  reg_addr_t i_waddr,
    input  xword_t    i_wdata,
    input  reg_addr_t i_raddr1,
    input  reg_addr_t i_raddr2,
    output xword_t    o_rdata1,
    output xword_t    o_rdata2
);

    xword_t r_regs [NREG];

    // NOTE: the array is a plain flop bank, so clearing every entry on reset is intended;
    // a RAM macro could not be reset this way.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != REG_ZERO)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Entry 0 is never written, so it stays zero after the first reset.
    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage merged with the integer register file, with write-through read bypass
// and a counter of retired register writes.
module wb_regfile
    import rv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    xword_t w_wb_data;
    logic   w_wb_we;
    xword_t w_raw1;
    xword_t w_raw2;
    xword_t w_rs1_data;
    xword_t w_rs2_data;
    xword_t r_wb_count;

    // NOTE: every signal driven from always_comb gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_wb_data = bus.result_alu;
        if (bus.memtoreg) begin
            w_wb_data = bus.readdata;
        end
    end

    // Writes to x0 and writes coinciding with reset are dropped here, before the array and counter.
    assign w_wb_we = bus.regwrite && (bus.rd != REG_ZERO) && !reset;

    regfile_core u_core (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_wb_we),
        .i_waddr  (bus.rd),
        .i_wdata  (w_wb_data),
        .i_raddr1 (bus.rs1_addr),
        .i_raddr2 (bus.rs2_addr),
        .o_rdata1 (w_raw1),
        .o_rdata2 (w_raw2)
    );

    always_comb begin
        w_rs1_data = bypass_read(reset, bus.rs1_addr, w_wb_we, bus.rd, w_wb_data, w_raw1);
        w_rs2_data = bypass_read(reset, bus.rs2_addr, w_wb_we, bus.rd, w_wb_data, w_raw2);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_count <= '0;
        end else if (w_wb_we) begin
            r_wb_count <= r_wb_count + xword_t'(1);
        end
    end

    assign bus.wb_data  = w_wb_data;
    assign bus.wb_rd    = bus.rd;
    assign bus.wb_we    = w_wb_we;
    assign bus.wb_count = r_wb_count;
    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: table-driven vectors plus reset, wrap and x0 sequences.
module tb_wb_regfile;
    import rv_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      rw;
        logic      m2r;
        reg_addr_t rd;
        xword_t    rdata;
        xword_t    alu;
        reg_addr_t rs1;
        reg_addr_t rs2;
        xword_t    e_wb;
        logic      e_we;
        xword_t    e_rs1;
        xword_t    e_rs2;
        xword_t    e_cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input xword_t act, input xword_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input reg_addr_t rd,
                         input xword_t rdata, input xword_t alu,
                         input reg_addr_t rs1, input reg_addr_t rs2);
        bus.regwrite   = rw;
        bus.memtoreg   = m2r;
        bus.rd         = rd;
        bus.readdata   = rdata;
        bus.result_alu = alu;
        bus.rs1_addr   = rs1;
        bus.rs2_addr   = rs2;
    endtask

    function automatic vec_t mk(logic rw, logic m2r, reg_addr_t rd, xword_t rdata, xword_t alu,
                                reg_addr_t rs1, reg_addr_t rs2, xword_t e_wb, logic e_we,
                                xword_t e_rs1, xword_t e_rs2, xword_t e_cnt);
        vec_t v;
        v.rw = rw;  v.m2r = m2r; v.rd = rd; v.rdata = rdata; v.alu = alu;
        v.rs1 = rs1; v.rs2 = rs2; v.e_wb = e_wb; v.e_we = e_we;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;

        //            rw  m2r rd  readdata                alu                     rs1 rs2 wb_data                 we  rs1_data                rs2_data                count
        vecs[0]  = mk(1, 0,  5, 64'h0,                  64'h1234,               5,  0,  64'h1234,               1, 64'h1234,               64'h0,                  64'd1);
        vecs[1]  = mk(0, 0,  5, 64'h0,                  64'h9999,               5,  5,  64'h9999,               0, 64'h1234,               64'h1234,               64'd1);
        vecs[2]  = mk(1, 1,  7, 64'hFFFF_FFFF_FFFF_FF80, 64'h1,                 7,  5,  64'hFFFF_FFFF_FFFF_FF80, 1, 64'hFFFF_FFFF_FFFF_FF80, 64'h1234,               64'd2);
        vecs[3]  = mk(0, 1,  7, 64'h0,                  64'h0,                  7,  7,  64'h0,                  0, 64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 64'd2);
        vecs[4]  = mk(1, 0,  0, 64'h0,                  64'hDEAD,               0,  0,  64'hDEAD,               0, 64'h0,                  64'h0,                  64'd2);
        vecs[5]  = mk(0, 0,  0, 64'h0,                  64'h0,                  0,  7,  64'h0,                  0, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 64'd2);
        vecs[6]  = mk(1, 0,  9, 64'h0,                  64'h11,                 9,  9,  64'h11,                 1, 64'h11,                 64'h11,                 64'd3);
        vecs[7]  = mk(1, 0,  9, 64'h0,                  64'h22,                 9,  5,  64'h22,                 1, 64'h22,                 64'h1234,               64'd4);
        vecs[8]  = mk(0, 0,  9, 64'h0,                  64'h0,                  9, 31,  64'h0,                  0, 64'h22,                 64'h0,                  64'd4);
        vecs[9]  = mk(1, 0, 31, 64'h5A5A,               64'hA5A5,              31, 30,  64'hA5A5,               1, 64'hA5A5,               64'h0,                  64'd5);
        vecs[10] = mk(0, 1, 31, 64'h77,                 64'h0,                 31,  1,  64'h77,                 0, 64'hA5A5,               64'h0,                  64'd5);

        // Reset, with a write presented during it that must be lost.
        reset = 1'b1;
        drive(0, 0, 0, '0, '0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(1, 0, 6, '0, 64'h55, 6, 6);
        #2;
        check("reset_rs1", bus.rs1_data, 64'h0);
        check("reset_rs2", bus.rs2_data, 64'h0);
        check("reset_we", xword_t'(bus.wb_we), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, '0, '0, 0, 0);
        #2;
        check("reset_count", bus.wb_count, 64'h0);
        for (int i = 1; i < NREG; i++) begin
            drive(0, 0, 0, '0, '0, reg_addr_t'(i), reg_addr_t'(NREG - i));
            #1;
            check($sformatf("clr_rs1_x%0d", i), bus.rs1_data, 64'h0);
            check($sformatf("clr_rs2_x%0d", NREG - i), bus.rs2_data, 64'h0);
        end

        // Table-driven vectors: combinational outputs before the edge, counter after it.
        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            drive(vecs[v].rw, vecs[v].m2r, vecs[v].rd, vecs[v].rdata, vecs[v].alu,
                  vecs[v].rs1, vecs[v].rs2);
            #2;
            check($sformatf("v%0d_wb_data", v), bus.wb_data, vecs[v].e_wb);
            check($sformatf("v%0d_wb_we", v), xword_t'(bus.wb_we), xword_t'(vecs[v].e_we));
            check($sformatf("v%0d_wb_rd", v), xword_t'(bus.wb_rd), xword_t'(vecs[v].rd));
            check($sformatf("v%0d_rs1", v), bus.rs1_data, vecs[v].e_rs1);
            check($sformatf("v%0d_rs2", v), bus.rs2_data, vecs[v].e_rs2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", v), bus.wb_count, vecs[v].e_cnt);
        end

        // Reset mid-stream: x3 written, then reset with a write to x4 pending.
        @(negedge clk);
        drive(1, 0, 3, '0, 64'hAA, 3, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 4, '0, 64'hBB, 3, 4);
        #2;
        check("midrst_rs1", bus.rs1_data, 64'h0);
        check("midrst_rs2", bus.rs2_data, 64'h0);
        check("midrst_we", xword_t'(bus.wb_we), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 4, '0, 64'h0, 3, 4);
        #2;
        check("postrst_x3", bus.rs1_data, 64'h0);
        check("postrst_x4", bus.rs2_data, 64'h0);
        check("postrst_count", bus.wb_count, 64'h0);
        @(negedge clk);
        drive(1, 0, 4, '0, 64'hCC, 4, 7);
        #2;
        check("firstwr_bypass", bus.rs1_data, 64'hCC);
        check("firstwr_x7_clr", bus.rs2_data, 64'h0);
        @(posedge clk);
        #1;
        check("firstwr_count", bus.wb_count, 64'h1);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 4, 9);
        #2;
        check("firstwr_x4", bus.rs1_data, 64'hCC);
        check("firstwr_x9_clr", bus.rs2_data, 64'h0);

        // Counter wrap from all-ones.
        force dut.r_wb_count = {XLEN{1'b1}};
        #1;
        release dut.r_wb_count;
        #1;
        check("wrap_preload", bus.wb_count, {XLEN{1'b1}});
        @(negedge clk);
        drive(1, 0, 2, '0, 64'h3, 2, 0);
        @(posedge clk);
        #1;
        check("wrap_count", bus.wb_count, 64'h0);
        @(negedge clk);
        drive(0, 0, 0, '0, '0, 2, 0);
        #2;
        check("wrap_x2", bus.rs1_data, 64'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage merged with the integer register file. It consumes the MEM/WB pipeline register outputs, selects the write-back value, and commits it to a 32 x 64-bit register file. Two combinational read ports feed the ID stage, with internal write-through bypass. It also exports the write-back value and destination to the forwarding unit, and maintains a retired-write counter.

Parameters:
XLEN, 64, data width of registers and datapath
NREG, 32, number of architectural registers (x0 hardwired to zero)
AW, 5, register address width (log2 NREG)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
memtoreg  in  1  from MEM/WB; 1 selects readdata, 0 selects result_alu
regwrite  in  1  from MEM/WB; write request
rd  in  AW  from MEM/WB; destination register
readdata  in  XLEN  from MEM/WB; load data
result_alu  in  XLEN  from MEM/WB; ALU result
rs1_addr  in  AW  ID-stage source 1 address
rs2_addr  in  AW  ID-stage source 2 address
rs1_data  out  XLEN  source 1 value (combinational)
rs2_data  out  XLEN  source 2 value (combinational)
wb_data  out  XLEN  selected write-back value (combinational), to forwarding unit
wb_rd  out  AW  equals rd (combinational), to forwarding unit
wb_we  out  1  effective write enable = regwrite & (rd != 0) & ~reset
wb_count  out  XLEN  registered count of effective writes

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- wb_data = memtoreg ? readdata : result_alu. Pure mux, zero latency.
- Commit: on the rising edge with wb_we = 1, regs[rd] <= wb_data. The new value is visible in the array from the next cycle.
- x0: a write to rd = 0 is discarded, with no array update and no count. Any read of address 0 returns 0 regardless of bypass.
- Read port, for each of rs1 and rs2, in priority order:
  1. If reset = 1, return 0.
  2. If addr = 0, return 0.
  3. If wb_we = 1 and addr = rd, return wb_data (write-through bypass, same cycle).
  4. Otherwise return regs[addr].
- rs1 and rs2 may address the same register; both return the identical value.
- wb_count:
  - On reset it becomes 0.
  - Otherwise it increments by 1 on each edge where wb_we = 1.
  - It wraps modulo 2^XLEN with no saturation.
- Reset, taking effect on the edge where reset = 1:
  - All regs[1..NREG-1] become 0 and wb_count becomes 0.
  - Any pending write that cycle is suppressed, because wb_we is forced 0.
  - rs1_data and rs2_data read 0 for the whole reset cycle.
- Reset mid-stream: a write presented in the same cycle as reset is lost. The first write accepted is the one presented in the first cycle after reset deasserts.
- Back-to-back writes to the same rd: the last write wins. Each write is visible via bypass in its own cycle.
- memtoreg has no effect when regwrite = 0. There are no X-propagation requirements on unused inputs.
- Storage: flop array; no memory macro inference is required. No stall input exists; upstream holds MEM/WB on stall.

Decomposition:
- Shared package rv_pkg:
  - XLEN and AW constants.
  - REG_ZERO = 0.
  - Typedef reg_addr_t [AW-1:0].
  - Typedef xword_t [XLEN-1:0].
- One natural sub-module, regfile_core: the array, reset clear, write port and raw read ports.
- The top level wb_regfile holds the write-back mux, bypass/x0 read logic, wb_we generation and wb_count.

Test Plan:
1. Reset, then read x1..x31 -> all 0; wb_count = 0.
2. regwrite = 1, memtoreg = 0, rd = 5, result_alu = 0x1234, rs1_addr = 5 in the same cycle -> rs1_data = 0x1234 (bypass) and wb_we = 1. Next cycle, with regwrite = 0 -> rs1_data = 0x1234 from the array; wb_count = 1.
3. regwrite = 1, memtoreg = 1, rd = 7, readdata = 0xFFFF_FFFF_FFFF_FF80, result_alu = 0x1 -> wb_data = 0xFFFF_FFFF_FFFF_FF80; x7 holds that value afterwards.
4. regwrite = 1, rd = 0, result_alu = 0xDEAD; rs1_addr = rs2_addr = 0 -> both read 0, wb_we = 0, wb_count unchanged; x0 reads 0 next cycle.
5. Write x3 = 0xAA, then assert reset for one cycle while regwrite = 1, rd = 4, result_alu = 0xBB -> x3 = 0, x4 = 0, and wb_count = 0 after reset.
6. Preload wb_count near wrap by forcing 2^64 - 1, then apply one effective write -> wb_count = 0. Separately, write rd = 9 with 0x11 then 0x22 on consecutive cycles -> x9 = 0x22.
